// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS-subset core: opcodes, fetch FSM states and
// the sequential PC increment.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam int PC_INCR = 4;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC generator: sequential, jump and taken-branch targets
// with jump taking priority over branch.
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [25:0]       i_instr_low,
  input  logic              i_jump,
  input  logic              i_branch,
  input  logic              i_zero,
  output logic [ADDR_W-1:0] o_next_pc
);

  logic [ADDR_W-1:0] w_pc4;
  logic [ADDR_W-1:0] w_jump_tgt;
  logic [ADDR_W-1:0] w_br_off;
  logic [ADDR_W-1:0] w_br_tgt;

  assign w_pc4      = i_pc + ADDR_W'(PC_INCR);
  // Jump keeps the region bits of pc+4 above the 28-bit word-aligned target.
  assign w_jump_tgt = {w_pc4[ADDR_W-1:28], i_instr_low, 2'b00};
  assign w_br_off   = {{(ADDR_W-18){i_instr_low[15]}}, i_instr_low[15:0], 2'b00};
  assign w_br_tgt   = w_pc4 + w_br_off;

  always_comb begin
    o_next_pc = w_pc4;
    if (i_jump) begin
      o_next_pc = w_jump_tgt;
    end else if (i_branch && i_zero) begin
      o_next_pc = w_br_tgt;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: requests a word from imem, presents it to the
// pipeline with valid/ready, then resolves the next PC from decoder controls.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_valid,
  output logic [31:0]       instr,
  output logic [5:0]        instr_opcode,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              ctl_jump,
  input  logic              ctl_branch,
  input  logic              ctl_halt,
  input  logic              alu_zero,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [31:0]       instr_count
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_next_pc;
  logic [31:0]       r_instr;
  logic [31:0]       r_count;
  logic              w_req;
  logic              w_valid;
  logic              w_halted;
  logic              w_latch;
  logic              w_retire;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_valid     = 1'b0;
    w_halted    = 1'b0;
    w_latch     = 1'b0;
    w_retire    = 1'b0;
    unique case (r_state)
      ST_FETCH: begin
        // Reset parks the FSM in FETCH; the request must stay low until rst drops.
        w_req       = ~rst;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_valid) begin
          w_latch     = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_valid = 1'b1;
        if (instr_ready) begin
          w_retire    = 1'b1;
          w_state_nxt = ctl_halt ? ST_HALTED : ST_FETCH;
        end
      end
      ST_HALTED: begin
        w_halted = 1'b1;
      end
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_count <= '0;
    end else begin
      if (w_latch) begin
        r_instr <= imem_rdata;
      end
      if (w_retire) begin
        r_count <= r_count + 32'd1;
        if (!ctl_halt) begin
          r_pc <= w_next_pc;
        end
      end
    end
  end

  next_pc_calc #(
    .ADDR_W(ADDR_W)
  ) u_next_pc (
    .i_pc       (r_pc),
    .i_instr_low(r_instr[25:0]),
    .i_jump     (ctl_jump),
    .i_branch   (ctl_branch),
    .i_zero     (alu_zero),
    .o_next_pc  (w_next_pc)
  );

  assign imem_req     = w_req;
  assign imem_addr    = r_pc;
  assign instr        = r_instr;
  assign instr_opcode = r_instr[31:26];
  assign instr_valid  = w_valid;
  assign pc           = r_pc;
  assign halted       = w_halted;
  assign instr_count  = r_count;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed fetch/jump/branch/stall/halt/
// reset scenarios plus randomized fetches against a transaction-level PC model.
module tb_instr_fetch;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_valid = 1'b0;
  logic [31:0] instr;
  logic [5:0]  instr_opcode;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        ctl_jump = 1'b0;
  logic        ctl_branch = 1'b0;
  logic        ctl_halt = 1'b0;
  logic        alu_zero = 1'b0;
  logic [31:0] pc;
  logic        halted;
  logic [31:0] instr_count;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_pc;
  logic [31:0] m_count;

  instr_fetch #(
    .ADDR_W  (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .instr       (instr),
    .instr_opcode(instr_opcode),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .ctl_jump    (ctl_jump),
    .ctl_branch  (ctl_branch),
    .ctl_halt    (ctl_halt),
    .alu_zero    (alu_zero),
    .pc          (pc),
    .halted      (halted),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural next-PC rule written as plain arithmetic on the word.
  function automatic logic [31:0] model_next(input logic [31:0] cur_pc, input logic [31:0] word,
                                             input logic j, input logic b, input logic z);
    logic [31:0] pc4;
    int          off;
    pc4 = cur_pc + 32'd4;
    if (j) return (pc4 & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
    if (b && z) begin
      off = int'($signed(word[15:0]));
      return pc4 + 32'(off * 4);
    end
    return pc4;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_pc"}, pc, 32'h0);
    check({tag, "_instr"}, instr, 32'h0);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    check({tag, "_halted"}, {31'd0, halted}, 32'd0);
    check({tag, "_count"}, instr_count, 32'h0);
  endtask

  task automatic fetch_req();
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("imem_req", {31'd0, imem_req}, 32'd1);
    check("imem_addr", imem_addr, m_pc);
  endtask

  task automatic fetch_resp(input logic [31:0] word, input int lat);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      imem_valid = 1'b0;
      check("req_single", {31'd0, imem_req}, 32'd0);
      check("wait_no_valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_valid = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = $urandom;
  endtask

  task automatic issue(input logic [31:0] word, input int stall,
                       input logic j, input logic b, input logic h, input logic z);
    check("instr_valid", {31'd0, instr_valid}, 32'd1);
    check("instr", instr, word);
    check("opcode", {26'd0, instr_opcode}, {26'd0, word[31:26]});
    check("issue_pc", pc, m_pc);
    check("issue_count", instr_count, m_count);
    for (int i = 0; i < stall; i++) begin
      instr_ready = 1'b0;
      ctl_jump    = 1'($urandom);
      ctl_branch  = 1'($urandom);
      ctl_halt    = 1'($urandom);
      alu_zero    = 1'($urandom);
      @(negedge clk);
      check("stall_instr", instr, word);
      check("stall_pc", pc, m_pc);
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_count", instr_count, m_count);
      check("stall_req", {31'd0, imem_req}, 32'd0);
    end
    instr_ready = 1'b1;
    ctl_jump    = j;
    ctl_branch  = b;
    ctl_halt    = h;
    alu_zero    = z;
    @(negedge clk);
    instr_ready = 1'b0;
    ctl_jump    = 1'b0;
    ctl_branch  = 1'b0;
    ctl_halt    = 1'b0;
    alu_zero    = 1'b0;
    m_count = m_count + 32'd1;
    if (h) begin
      check("halt_flag", {31'd0, halted}, 32'd1);
      check("halt_valid", {31'd0, instr_valid}, 32'd0);
      check("halt_req", {31'd0, imem_req}, 32'd0);
      check("halt_pc", pc, m_pc);
    end else begin
      m_pc = model_next(m_pc, word, j, b, z);
      check("next_req", {31'd0, imem_req}, 32'd1);
      check("next_pc", pc, m_pc);
    end
    check("retired", instr_count, m_count);
  endtask

  task automatic do_fetch(input logic [31:0] word, input int lat, input int stall,
                          input logic j, input logic b, input logic h, input logic z);
    fetch_req();
    fetch_resp(word, lat);
    issue(word, stall, j, b, h, z);
  endtask

  initial begin
    logic [31:0] w;
    int          lat;
    int          stall;
    logic        j;
    logic        b;
    logic        z;

    m_pc    = 32'h0;
    m_count = 32'h0;
    repeat (2) @(negedge clk);
    check_reset("por");
    rst = 1'b0;
    #1;

    // Sequential fetch of addi words
    for (int i = 0; i < 3; i++) do_fetch(32'h2008_0005, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("seq_count", instr_count, 32'd3);
    check("seq_addr", imem_addr, 32'h0000_000C);
    do_fetch(32'h2008_0005, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pre_jump_pc", pc, 32'h0000_0010);

    // Jump, then jump back to 0x20 for the branch pair
    do_fetch(32'h0800_0040, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("jump_addr", imem_addr, 32'h0000_0100);
    do_fetch(32'h0800_0008, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("jump_back", imem_addr, 32'h0000_0020);
    do_fetch(32'h1000_FFFE, 1, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("br_taken", imem_addr, 32'h0000_001C);
    do_fetch(32'h2008_0005, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_fetch(32'h1000_FFFE, 1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("br_not_taken", imem_addr, 32'h0000_0024);

    // Jump and branch both set: jump wins
    do_fetch(32'h0800_0040, 1, 0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("jump_over_br", imem_addr, 32'h0000_0100);

    // Long imem latency and pipeline back-pressure
    do_fetch(32'h8C01_0004, 5, 3, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized fetches
    for (int i = 0; i < 40; i++) begin
      w     = $urandom;
      lat   = $urandom_range(1, 4);
      stall = $urandom_range(0, 3);
      j     = ($urandom_range(0, 3) == 0);
      b     = ($urandom_range(0, 2) == 0);
      z     = 1'($urandom);
      do_fetch(w, lat, stall, j, b, 1'b0, z);
    end

    // Halt: counted as retired, then everything is ignored
    do_fetch({OP_HALT, 26'd0}, 2, 1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      imem_valid  = 1'($urandom);
      imem_rdata  = $urandom;
      instr_ready = 1'($urandom);
      ctl_jump    = 1'($urandom);
      ctl_branch  = 1'($urandom);
      ctl_halt    = 1'($urandom);
      alu_zero    = 1'($urandom);
      @(negedge clk);
      check("hold_halted", {31'd0, halted}, 32'd1);
      check("hold_req", {31'd0, imem_req}, 32'd0);
      check("hold_valid", {31'd0, instr_valid}, 32'd0);
      check("hold_pc", pc, m_pc);
      check("hold_count", instr_count, m_count);
    end
    imem_valid  = 1'b0;
    instr_ready = 1'b0;
    ctl_jump    = 1'b0;
    ctl_branch  = 1'b0;
    ctl_halt    = 1'b0;
    alu_zero    = 1'b0;

    // Reset out of HALTED, asserted between clock edges
    #2 rst = 1'b1;
    #1 check_reset("halt_rst");
    @(negedge clk);
    rst     = 1'b0;
    m_pc    = 32'h0;
    m_count = 32'h0;
    #1;
    do_fetch(32'h2008_0005, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-WAIT, then a stale response during the restarted FETCH
    fetch_req();
    @(negedge clk);
    check("in_wait_valid", {31'd0, instr_valid}, 32'd0);
    #2 rst = 1'b1;
    #1 check_reset("wait_rst");
    @(negedge clk);
    rst     = 1'b0;
    m_pc    = 32'h0;
    m_count = 32'h0;
    #1;
    fetch_req();
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    fetch_resp(32'h2009_0007, 1);
    issue(32'h2009_0007, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_fetch(32'h2008_0005, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("restart_addr", imem_addr, 32'h0000_0008);
    check("restart_count", instr_count, 32'd2);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch sequencer that produces `instr`/`instr_opcode` for the control decoder and consumes the decoder's `ctl_jump`, `ctl_branch` and `ctl_halt` outputs to choose the next PC.
- Sits between instruction memory and the control/datapath of the single-issue MIPS-subset core.
- Runs a memory request/valid handshake toward imem and a valid/ready handshake toward the pipeline.
- Resolves PC+4, j, beq and halt.

Parameters:
- ADDR_W, 32, PC and imem address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  one-cycle fetch request pulse.
- imem_addr  out  ADDR_W  fetch address; equals pc.
- imem_rdata  in  32  instruction word; valid when imem_valid=1.
- imem_valid  in  1  read-data strobe, at least 1 cycle after imem_req.
- instr  out  32  held instruction word.
- instr_opcode  out  6  instr[31:26], fed to the control decoder.
- instr_valid  out  1  instr is presented to the pipeline.
- instr_ready  in  1  pipeline accepts instr.
- ctl_jump  in  1  from the control decoder.
- ctl_branch  in  1  from the control decoder.
- ctl_halt  in  1  from the control decoder.
- alu_zero  in  1  beq comparison result; valid in the handshake cycle.
- pc  out  ADDR_W  address of the current instruction.
- halted  out  1  core is stopped.
- instr_count  out  32  retired-instruction counter.

Behaviour:
- Reset (async, rst=1):
  - state=FETCH, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, halted=0, instr_count=0.
  - First imem_req is asserted the cycle after rst deasserts.
- States: FETCH, WAIT, ISSUE, HALTED.
- FETCH: imem_req=1 for exactly this cycle; imem_addr=pc; next state is WAIT. imem_valid in FETCH is ignored, which discards a stale response left over from before reset.
- WAIT:
  - On imem_valid=1, latch instr=imem_rdata and go to ISSUE.
  - Otherwise hold, with no timeout.
  - Minimum latency from imem_req to instr_valid is 2 cycles.
- ISSUE:
  - instr_valid=1. instr, instr_opcode and pc are stable until the handshake.
  - Handshake is instr_valid & instr_ready. On handshake, instr_count += 1 (wraps at 2^32) and the next PC is chosen by priority:
    - ctl_halt=1 -> HALTED; pc unchanged.
    - ctl_jump=1 -> pc = {pc4[31:28], instr[25:0], 2'b00}, where pc4 = pc+4.
    - ctl_branch=1 & alu_zero=1 -> pc = pc4 + ({{14{instr[15]}}, instr[15:0], 2'b00}).
    - Otherwise pc = pc4.
  - After any non-halt case, next state is FETCH.
  - alu_zero, ctl_* are sampled only in the handshake cycle.
  - No handshake -> hold ISSUE; all outputs stable.
- HALTED:
  - halted=1, instr_valid=0, imem_req=0.
  - All inputs are ignored; only rst exits. The halt instruction counts as retired.
- Arithmetic: all PC arithmetic is modulo 2^ADDR_W; wrap at 32'hFFFF_FFFC -> 0 is legal.
- Simultaneous ctl_jump and ctl_branch cannot come from the decoder; if both are set, jump wins.
- Mid-operation rst in any state returns immediately to the reset values.
- imem contract: imem must not return more than one imem_valid per imem_req.
- instr_opcode is a combinational slice of the instr register.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants: OP_RTYPE=6'h00, OP_ADDI=6'h08, OP_ADDIU=6'h09, OP_LW=6'h23, OP_SW=6'h2B, OP_BEQ=6'h04, OP_J=6'h02, OP_HALT=6'h3F.
  - fetch state encoding.
  - PC_INCR=4.
- One natural sub-module: next_pc_calc, a combinational target generator (pc4, jump target, branch target, priority mux). The FSM and registers stay in instr_fetch.

Test Plan:
- Sequential fetch: reset, imem returns 32'h2008_0005 (addi) with 1-cycle latency, instr_ready=1, decoder ctl_*=0 -> imem_addr sequence 0, 4, 8; instr_count=3 after three handshakes.
- Jump: at pc=32'h0000_0010, instr=32'h0800_0040, ctl_jump=1 -> next imem_addr=32'h0000_0100.
- Branch, taken then not taken, at pc=32'h20 with instr=32'h1000_FFFE and ctl_branch=1:
  - alu_zero=1 -> next addr 32'h0000_001C.
  - alu_zero=0 -> next addr 32'h24.
- Stall/latency: imem_valid delayed 5 cycles, then instr_ready held low 3 cycles -> instr/pc stable, single imem_req, instr_count increments once.
- Halt: instr=32'hFC00_0000, ctl_halt=1 -> halted=1 the next cycle; no further imem_req for 20 cycles; pc unchanged; rst -> pc=RESET_PC, halted=0.
- Async reset mid-WAIT: rst pulse asserted between clock edges -> outputs reset immediately; a stale imem_valid in the following FETCH cycle is ignored; fetch restarts at RESET_PC.
